lzy_serial_tx: RTL and testbench

- Parallel-in, serial-out frame transmitter, in the style of a 74HC165 PISO shift register.
- Adds a valid/ready load handshake, a per-bit clock divider and start/parity/stop framing.
- It is the sending end of the lab's serial link. It drives one line pair (Sout/Soutn) toward the team's serial receiver block on the experiment board.
- Built entirely from edge-triggered flops with async clear.

---
 rtl/lzy_serial_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_lzy_serial_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lzy_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lzy_serial_tx
//  Description : Parallel-in / serial-out frame transmitter (74HC165-style
//                PISO) with a valid/ready load handshake, a per-bit clock
//                divider and start / data / optional even-parity / stop
//                framing. Sending end of the lab serial link.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    : payload bits per frame (1..16)
//    DIV       : Clk cycles per serial bit (>=1)
//    PARITY_EN : 1 = append even-parity bit after the data bits
//    MSB_FIRST : 0 = LSB shifted first, 1 = MSB shifted first
//  Ports
//    Clk   in   rising-edge system clock
//    Rd    in   asynchronous active-low reset
//    Din   in   parallel word, sampled only on an accepting edge
//    Valid in   Din holds a word to send
//    Ready out  block can accept a word this cycle
//    Sout  out  serial line, idle high
//    Soutn out  complement of Sout
//    Busy  out  frame in progress (START through STOP)
//    Done  out  one-cycle pulse on the final cycle of the stop bit
// ============================================================================
module lzy_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic              Clk,
  input  logic              Rd,
  input  logic [DATA_W-1:0] Din,
  input  logic              Valid,
  output logic              Ready,
  output logic              Sout,
  output logic              Soutn,
  output logic              Busy,
  output logic              Done
);

  // Counter widths never collapse to zero bits.
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]        state,   state_nx;
  logic [TW-1:0]     timer,   timer_nx;
  logic [IW-1:0]     bit_idx, bit_idx_nx;
  logic [DATA_W-1:0] shreg,   shreg_nx;
  logic              par,     par_nx;

  logic              sout_q,  sout_nx;
  logic              ready_q, ready_nx;
  logic              busy_q,  busy_nx;
  logic              done_q,  done_nx;

  logic              accept;
  logic              timer_last;
  logic              final_stop_nx;
  logic [DATA_W-1:0] shreg_shifted;
  logic              next_bit;

  // Ready is a registered output, so the handshake never depends
  // combinationally on Valid.
  assign accept     = Valid & ready_q;
  assign timer_last = (timer == TIMER_LAST);

  // --------------------------------------------------------------------------
  // Bit ordering: which end of the register is on the line, and which way
  // the register moves at the end of each data bit.
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shreg_shifted = shreg << 1;
      assign next_bit      = shreg_nx[DATA_W-1];
    end else begin : g_lsb_first
      assign shreg_shifted = shreg >> 1;
      assign next_bit      = shreg_nx[0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_nx     = par;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx   = ST_START;
          timer_nx   = '0;
          bit_idx_nx = '0;
          shreg_nx   = Din;
          par_nx     = ^Din;
        end
      end

      ST_START: begin
        if (timer_last) begin
          state_nx = ST_DATA;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TIMER_ONE;
        end
      end

      ST_DATA: begin
        if (timer_last) begin
          timer_nx = '0;
          shreg_nx = shreg_shifted;
          if (bit_idx == IDX_LAST) begin
            bit_idx_nx = '0;
            state_nx   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_nx = bit_idx + IDX_ONE;
          end
        end else begin
          timer_nx = timer + TIMER_ONE;
        end
      end

      ST_PARITY: begin
        if (timer_last) begin
          state_nx = ST_STOP;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TIMER_ONE;
        end
      end

      ST_STOP: begin
        if (timer_last) begin
          timer_nx = '0;
          // Ready is high in this cycle, so a waiting word starts the next
          // frame with no idle gap.
          if (accept) begin
            state_nx   = ST_START;
            bit_idx_nx = '0;
            shreg_nx   = Din;
            par_nx     = ^Din;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          timer_nx = timer + TIMER_ONE;
        end
      end

      default: begin
        state_nx   = ST_IDLE;
        timer_nx   = '0;
        bit_idx_nx = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from next state, so every output comes straight from a flop
  // and the line changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    final_stop_nx = (state_nx == ST_STOP) && (timer_nx == TIMER_LAST);
    ready_nx      = (state_nx == ST_IDLE) || final_stop_nx;
    busy_nx       = (state_nx != ST_IDLE);
    done_nx       = final_stop_nx;

    case (state_nx)
      ST_START:  sout_nx = 1'b0;
      ST_DATA:   sout_nx = next_bit;
      ST_PARITY: sout_nx = par_nx;
      default:   sout_nx = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rd) begin
    if (!Rd) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
      sout_q  <= sout_nx;
      ready_q <= ready_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  assign Sout  = sout_q;
  assign Soutn = ~sout_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lzy_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lzy_serial_tx
//  Description : Self-checking bench for lzy_serial_tx. A cycle-level model
//                expands each accepted word into the list of line levels it
//                must produce; every cycle the DUT outputs are compared with
//                the head of that list. A second instance covers DIV=1,
//                no parity, MSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lzy_serial_tx;

  localparam int W   = 8;
  localparam int DV  = 4;
  localparam int PE  = 1;
  localparam int MSB = 0;

  logic         Clk = 1'b0;
  logic         Rd;
  logic [W-1:0] Din, Din2;
  logic         Valid, Valid2;
  logic         Ready, Sout, Soutn, Busy, Done;
  logic         Ready2, Sout2, Soutn2, Busy2, Done2;

  always #5 Clk = ~Clk;

  lzy_serial_tx #(.DATA_W(W), .DIV(DV), .PARITY_EN(PE), .MSB_FIRST(MSB)) dut (
    .Clk(Clk), .Rd(Rd), .Din(Din), .Valid(Valid), .Ready(Ready),
    .Sout(Sout), .Soutn(Soutn), .Busy(Busy), .Done(Done)
  );

  lzy_serial_tx #(.DATA_W(W), .DIV(1), .PARITY_EN(0), .MSB_FIRST(1)) dut2 (
    .Clk(Clk), .Rd(Rd), .Din(Din2), .Valid(Valid2), .Ready(Ready2),
    .Sout(Sout2), .Soutn(Soutn2), .Busy(Busy2), .Done(Done2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit q[$];          // remaining line levels, one entry per cycle
  bit m_ready = 1'b1;
  bit e_sout, e_busy, e_done, e_ready;
  bit accepted;
  int cyc, busy_cnt, done_cnt, last_done_cyc, ready_busy_cnt, n_acc, acc_cyc;

  task automatic push_frame(input logic [W-1:0] d);
    bit lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < W; i++)
      lv.push_back(MSB != 0 ? d[W-1-i] : d[i]);
    if (PE != 0) lv.push_back(bit'($countones(d) % 2));
    lv.push_back(1'b1);
    foreach (lv[k])
      for (int r = 0; r < DV; r++) q.push_back(lv[k]);
  endtask

  task automatic clr_stats();
    cyc = 0; busy_cnt = 0; done_cnt = 0; last_done_cyc = 0;
    ready_busy_cnt = 0; n_acc = 0; acc_cyc = 0;
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    accepted = 1'b0;
    if (!Rd) begin
      q.delete();
    end else if (Valid && m_ready) begin
      accepted = 1'b1;
      push_frame(Din);
    end
    if (q.size() > 0) begin
      e_sout = q.pop_front();
      e_busy = 1'b1;
      e_done = (q.size() == 0);
    end else begin
      e_sout = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end
    e_ready = !e_busy || e_done;
    m_ready = e_ready;
    #1;
    cyc++;
    if (accepted) begin n_acc++; acc_cyc = cyc; end
    check_eq("line", 32'({Sout, Soutn, Ready, Busy, Done}),
             32'({e_sout, ~e_sout, e_ready, e_busy, e_done}));
    if (Busy) busy_cnt++;
    if (Done) begin done_cnt++; last_done_cyc = cyc; end
    if (Ready && Busy) ready_busy_cnt++;
  endtask

  logic [10:0] obs;
  logic        par1, par2;
  logic        exp2 [10];

  initial begin
    Rd = 1'b0; Valid = 1'b1; Din = 8'h77; Valid2 = 1'b0; Din2 = '0;

    // Reset held with Valid high: everything stays idle.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rst_dut2", 32'({Sout2, Soutn2, Ready2, Busy2, Done2}), 32'(5'b10100));
    end
    Valid = 1'b0;
    Rd    = 1'b1;

    // Single word 0xA5.
    clr_stats(); obs = '0;
    Valid = 1'b1; Din = 8'hA5;
    for (int i = 0; i < 50; i++) begin
      tick();
      Valid = 1'b0; Din = W'($urandom);
      if (cyc <= 44 && ((cyc - 1) % 4) == 0) obs = {obs[9:0], Sout};
    end
    check_eq("a5_levels", 32'(obs), 32'(11'b01010010101));
    check_eq("a5_busy_cnt", 32'(busy_cnt), 32'd44);
    check_eq("a5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("a5_done_cyc", 32'(last_done_cyc), 32'd44);
    check_eq("a5_ready_in_frame", 32'(ready_busy_cnt), 32'd1);

    // Back-to-back 0x01 then 0xFF with Valid held high.
    clr_stats();
    Valid = 1'b1; Din = 8'h01;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cyc == 37) par1 = Sout;
      if (cyc == 81) par2 = Sout;
      if (n_acc == 1) Din = 8'hFF;
      if (n_acc >= 2) Valid = 1'b0;
    end
    check_eq("b2b_second_start", 32'(acc_cyc), 32'd45);
    check_eq("b2b_par1", 32'(par1), 32'd1);
    check_eq("b2b_par2", 32'(par2), 32'd0);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check_eq("b2b_busy_cnt", 32'(busy_cnt), 32'd88);

    // Valid with 0x3C while busy is ignored.
    clr_stats();
    Valid = 1'b1; Din = 8'h96;
    tick();
    Valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    Valid = 1'b1; Din = 8'h3C;
    for (int i = 0; i < 10; i++) tick();
    Valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check_eq("ign_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("ign_busy_cnt", 32'(busy_cnt), 32'd44);

    // Asynchronous abort during data bit 3 of 0x5A, then a clean 0x12 frame.
    clr_stats();
    Valid = 1'b1; Din = 8'h5A;
    tick();
    Valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check_eq("abort_busy_before", 32'(Busy), 32'd1);
    #2 Rd = 1'b0;
    #1;
    q.delete(); m_ready = 1'b1;
    check_eq("abort_async", 32'({Sout, Soutn, Ready, Busy, Done}), 32'(5'b10100));
    tick(); tick();
    Rd = 1'b1;
    clr_stats();
    Valid = 1'b1; Din = 8'h12;
    tick();
    Valid = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check_eq("abort_resume_busy", 32'(busy_cnt), 32'd44);
    check_eq("abort_resume_done", 32'(done_cnt), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      Valid = ($urandom_range(0, 3) == 0);
      Din   = W'($urandom);
      tick();
    end
    Valid = 1'b0;
    for (int i = 0; i < 50; i++) tick();

    // DIV=1, no parity, MSB first: 0x80.
    exp2 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Valid2 = 1'b1; Din2 = 8'h80;
    for (int k = 0; k < 12; k++) begin
      tick();
      Valid2 = 1'b0; Din2 = W'($urandom);
      if (k < 10) begin
        check_eq($sformatf("d1_sout_c%0d", k + 1), 32'(Sout2), 32'(exp2[k]));
        check_eq($sformatf("d1_done_c%0d", k + 1), 32'(Done2), 32'(k == 9));
      end else begin
        check_eq("d1_idle", 32'({Sout2, Busy2, Ready2}), 32'(3'b101));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
